// File: rtl/sram_pkg.sv
// Shared types and parameter-rule helpers for the 1RW/1R SRAM behavioural model.
package sram_pkg;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } sram_state_t;

   // True when the slice width divides the word and the read latency is supported.
   function automatic bit params_ok(input int data_width, input int write_size,
                                    input int read_latency);
      return (write_size > 0) && (data_width % write_size == 0) &&
             (read_latency == 1 || read_latency == 2);
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read output stage for one SRAM port: READ_LATENCY registers of data, valid and
// collision tag. Output data holds its last value whenever no new read arrives.
module sram_rd_pipe #(
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_word,
   input  logic                  col_in,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  col_out
);

   logic [DATA_WIDTH-1:0]   data_reg [READ_LATENCY];
   logic [READ_LATENCY-1:0] valid_reg;
   logic [READ_LATENCY-1:0] col_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < READ_LATENCY; i++) data_reg[i] <= '0;
         valid_reg <= '0;
         col_reg   <= '0;
      end else begin
         valid_reg[0] <= rd_en;
         col_reg[0]   <= col_in;
         if (rd_en) data_reg[0] <= rd_word;
         // Later stages only advance when a real read occupies the stage before.
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            col_reg[i]   <= col_reg[i-1];
            if (valid_reg[i-1]) data_reg[i] <= data_reg[i-1];
         end
      end
   end

   assign dout    = data_reg[READ_LATENCY-1];
   assign col_out = valid_reg[READ_LATENCY-1] & col_reg[READ_LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_param.sv
// Behavioural 1RW/1R SRAM macro with write masking, 1- or 2-cycle reads,
// read-before-write collision reporting and an optional zeroing sweep after reset.
module sram_1rw1r_param
   import sram_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int WRITE_SIZE     = 8,
   parameter int NUM_WMASKS     = DATA_WIDTH / WRITE_SIZE,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk0,
   input  logic                  rst0,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  busy,
   output logic                  collision
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   if (!params_ok(DATA_WIDTH, WRITE_SIZE, READ_LATENCY)) begin : g_param_check
      $error("sram_1rw1r_param: WRITE_SIZE must divide DATA_WIDTH and READ_LATENCY must be 1 or 2");
   end

   sram_state_t           state_reg, state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt_reg, clr_cnt_next;
   logic                  clr_we;

   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_reg   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      case (state_reg)
         S_CLEAR: begin
            clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
            if (&clr_cnt_reg) state_next = S_IDLE;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy   = 1'b0;
      clr_we = 1'b0;
      case (state_reg)
         S_CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
         end
         default: ;
      endcase
   end

   // Requests are dropped, not queued, while sweeping or in reset.
   logic req_ok, rd0, wr0, rd1, col;
   assign req_ok = !busy && !rst0;
   assign rd0    = req_ok && !csb0 && web0;
   assign wr0    = req_ok && !csb0 && !web0;
   assign rd1    = req_ok && !csb1;
   assign col    = rd1 && wr0 && (addr0 == addr1) && (|wmask0);

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_WMASKS-1:0] wr_mask;
   assign wr_en   = clr_we | wr0;
   assign wr_addr = clr_we ? clr_cnt_reg : addr0;
   assign wr_data = clr_we ? '0 : din0;
   assign wr_mask = clr_we ? '1 : wmask0;

   always_ff @(posedge clk0) begin
      if (wr_en) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wr_mask[i])
               mem_reg[wr_addr][i*WRITE_SIZE +: WRITE_SIZE] <= wr_data[i*WRITE_SIZE +: WRITE_SIZE];
         end
      end
   end

   // The array is sampled in the same edge as the write, so a colliding read sees old data.
   logic [1:0]                 rd_en, col_tag, col_out;
   logic [1:0][DATA_WIDTH-1:0] rd_word, rd_dout;
   assign rd_en      = {rd1, rd0};
   assign col_tag    = {col, 1'b0};
   assign rd_word[0] = mem_reg[addr0];
   assign rd_word[1] = mem_reg[addr1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      sram_rd_pipe #(
         .DATA_WIDTH   (DATA_WIDTH),
         .READ_LATENCY (READ_LATENCY)
      ) u_rd_pipe (
         .clk     (clk0),
         .srst    (rst0),
         .rd_en   (rd_en[gi]),
         .rd_word (rd_word[gi]),
         .col_in  (col_tag[gi]),
         .dout    (rd_dout[gi]),
         .col_out (col_out[gi])
      );
   end

   assign dout0     = rd_dout[0];
   assign dout1     = rd_dout[1];
   assign collision = |col_out;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: default instance against an array model with random
// traffic, plus a 16-bit / latency-2 / no-clear instance driven with directed steps.
module tb_sram_1rw1r_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, csb0, web0, csb1, busy, collision;
   logic [0:0] wmask0;
   logic [3:0] addr0, addr1;
   logic [7:0] din0, dout0, dout1;

   sram_1rw1r_param u_dut (
      .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
      .addr0(addr0), .din0(din0), .dout0(dout0), .csb1(csb1), .addr1(addr1),
      .dout1(dout1), .busy(busy), .collision(collision)
   );

   logic        w_rst, w_csb0, w_web0, w_csb1, w_busy, w_collision;
   logic [1:0]  w_wmask0;
   logic [3:0]  w_addr0, w_addr1;
   logic [15:0] w_din0, w_dout0, w_dout1;

   sram_1rw1r_param #(
      .DATA_WIDTH(16), .ADDR_WIDTH(4), .WRITE_SIZE(8), .NUM_WMASKS(2),
      .READ_LATENCY(2), .CLEAR_ON_RESET(0)
   ) u_wide (
      .clk0(clk), .rst0(w_rst), .csb0(w_csb0), .web0(w_web0), .wmask0(w_wmask0),
      .addr0(w_addr0), .din0(w_din0), .dout0(w_dout0), .csb1(w_csb1), .addr1(w_addr1),
      .dout1(w_dout1), .busy(w_busy), .collision(w_collision)
   );

   int         n_assert = 0;
   int         n_fail   = 0;
   int         n_txn    = 0;
   logic [7:0] mdl [16];
   logic [7:0] exp0, exp1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One default-instance transaction; model reads happen before the model write (read-before-write).
   task automatic cyc(input logic c0, input logic w0, input logic m0, input logic [3:0] a0,
                      input logic [7:0] d0, input logic c1, input logic [3:0] a1);
      logic col;
      csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
      if (!c0 && w0) exp0 = mdl[a0];
      if (!c1) exp1 = mdl[a1];
      col = !c0 && !w0 && m0 && !c1 && (a0 == a1);
      if (!c0 && !w0 && m0) mdl[a0] = d0;
      tick();
      n_txn++;
      $display("txn %0d: p0 cs=%b we=%b m=%b a=%0d d=%0h | p1 cs=%b a=%0d -> dout0=%0h dout1=%0h col=%b",
               n_txn, !c0, !w0, m0, a0, d0, !c1, a1, dout0, dout1, collision);
      check("dout0", 32'(dout0), 32'(exp0));
      check("dout1", 32'(dout1), 32'(exp1));
      check("collision", 32'(collision), 32'(col));
      csb0 = 1'b1; csb1 = 1'b1;
   endtask

   initial begin
      int n;
      logic [3:0] ra0, ra1;
      rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; wmask0 = 1'b1; addr0 = '0; din0 = '0;
      csb1 = 1'b1; addr1 = '0;
      w_rst = 1'b1; w_csb0 = 1'b1; w_web0 = 1'b1; w_wmask0 = 2'b11; w_addr0 = '0;
      w_din0 = '0; w_csb1 = 1'b1; w_addr1 = '0;

      tick(); tick();
      check("rst_dout0", 32'(dout0), 32'h0);
      check("rst_dout1", 32'(dout1), 32'h0);
      check("rst_collision", 32'(collision), 32'h0);
      check("rst_busy", 32'(busy), 32'h1);
      check("w_rst_busy", 32'(w_busy), 32'h0);
      w_rst = 1'b0;

      // Full clear sweep after release.
      rst0 = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      check("clear_len", n, 16);
      for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
      exp0 = 8'h00; exp1 = 8'h00;
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b1, 4'(i), 8'h00, 1'b0, 4'(15 - i));

      // Directed writes and shuffled reads.
      cyc(1'b0, 1'b0, 1'b1, 4'd3, 8'd217, 1'b1, 4'd0);
      cyc(1'b0, 1'b0, 1'b1, 4'd13, 8'd144, 1'b1, 4'd0);
      cyc(1'b0, 1'b0, 1'b1, 4'd9, 8'd88, 1'b1, 4'd0);
      cyc(1'b0, 1'b1, 1'b1, 4'd9, 8'h00, 1'b0, 4'd3);
      check("rd9_p0_const", 32'(dout0), 32'd88);
      cyc(1'b0, 1'b1, 1'b1, 4'd13, 8'h00, 1'b0, 4'd9);
      cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'h00, 1'b0, 4'd13);
      check("rd3_p0_const", 32'(dout0), 32'd217);
      check("rd13_p1_const", 32'(dout1), 32'd144);

      // Same-address collision, then masked-off write, then dual read.
      cyc(1'b0, 1'b0, 1'b1, 4'd4, 8'd201, 1'b1, 4'd0);
      cyc(1'b0, 1'b0, 1'b1, 4'd4, 8'd125, 1'b0, 4'd4);
      check("col_pre_data", 32'(dout1), 32'd201);
      check("col_flag", 32'(collision), 32'h1);
      cyc(1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 4'd4);
      check("col_post_data", 32'(dout1), 32'd125);
      check("col_post_flag", 32'(collision), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 4'd4, 8'h55, 1'b0, 4'd4);
      cyc(1'b0, 1'b1, 1'b1, 4'd4, 8'h00, 1'b0, 4'd4);
      cyc(1'b0, 1'b0, 1'b1, 4'd7, 8'h3c, 1'b1, 4'd0);
      cyc(1'b0, 1'b1, 1'b1, 4'd7, 8'h00, 1'b0, 4'd7);

      // Random traffic, port 1 biased towards port 0's address to provoke collisions.
      for (int t = 0; t < 200; t++) begin
         ra0 = 4'($urandom_range(0, 15));
         ra1 = ($urandom_range(0, 2) == 0) ? ra0 : 4'($urandom_range(0, 15));
         cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) != 0), ra0, 8'($urandom),
             1'($urandom_range(0, 3) == 0), ra1);
      end

      // Reset at clear address 7 restarts the sweep; a write attempted while busy is dropped.
      rst0 = 1'b1; tick();
      rst0 = 1'b0;
      repeat (7) tick();
      rst0 = 1'b1; tick();
      check("midclear_busy", 32'(busy), 32'h1);
      check("midclear_dout0", 32'(dout0), 32'h0);
      rst0 = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         csb0 = (n == 11) ? 1'b0 : 1'b1;
         web0 = 1'b0; addr0 = 4'd2; din0 = 8'hff; wmask0 = 1'b1;
         n++;
         tick();
      end
      csb0 = 1'b1; web0 = 1'b1;
      check("restart_clear_len", n, 16);
      for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
      exp0 = 8'h00; exp1 = 8'h00;
      cyc(1'b0, 1'b1, 1'b1, 4'd2, 8'h00, 1'b0, 4'd2);
      check("busy_write_dropped", 32'(dout0), 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 4'd3, 8'h00, 1'b0, 4'd13);

      // Wide instance: masked write with two-cycle reads.
      w_csb0 = 1'b0; w_web0 = 1'b0; w_wmask0 = 2'b11; w_addr0 = 4'd5; w_din0 = 16'hABCD; tick();
      w_wmask0 = 2'b01; w_din0 = 16'h1234; tick();
      w_web0 = 1'b1; w_csb1 = 1'b0; w_addr1 = 4'd5; tick();
      w_csb0 = 1'b1; w_csb1 = 1'b1;
      check("w_lat2_early", 32'(w_dout0), 32'h0);
      tick();
      check("w_mask_p0", 32'(w_dout0), 32'hAB34);
      check("w_mask_p1", 32'(w_dout1), 32'hAB34);

      // Contents survive reset when no clear is configured.
      w_csb0 = 1'b0; w_web0 = 1'b0; w_wmask0 = 2'b11; w_addr0 = 4'd15; w_din0 = 16'd248; tick();
      w_csb0 = 1'b1; w_web0 = 1'b1;
      w_rst = 1'b1; tick();
      check("w_busy_in_rst", 32'(w_busy), 32'h0);
      check("w_rst_dout0", 32'(w_dout0), 32'h0);
      w_rst = 1'b0;
      w_csb0 = 1'b0; w_addr0 = 4'd15; tick();
      w_csb0 = 1'b1;
      check("w_busy_after_rst", 32'(w_busy), 32'h0);
      check("w_survive_early", 32'(w_dout0), 32'h0);
      tick();
      check("w_survive", 32'(w_dout0), 32'd248);

      // Reset with a read in flight discards it.
      w_csb0 = 1'b0; w_addr0 = 4'd5; tick();
      w_csb0 = 1'b1; w_rst = 1'b1; tick();
      w_rst = 1'b0;
      check("w_cancel_a", 32'(w_dout0), 32'h0);
      tick();
      check("w_cancel_b", 32'(w_dout0), 32'h0);
      tick();
      check("w_cancel_c", 32'(w_dout0), 32'h0);

      // Collision flag aligned with two-cycle dout1.
      w_csb0 = 1'b0; w_web0 = 1'b0; w_wmask0 = 2'b10; w_addr0 = 4'd5; w_din0 = 16'hEE00;
      w_csb1 = 1'b0; w_addr1 = 4'd5; tick();
      w_csb0 = 1'b1; w_web0 = 1'b1; w_csb1 = 1'b1;
      check("w_col_early", 32'(w_collision), 32'h0);
      tick();
      check("w_col_flag", 32'(w_collision), 32'h1);
      check("w_col_data", 32'(w_dout1), 32'hAB34);
      tick();
      check("w_col_pulse_end", 32'(w_collision), 32'h0);
      check("w_col_hold", 32'(w_dout1), 32'hAB34);
      w_csb1 = 1'b0; w_addr1 = 4'd5; tick();
      w_csb1 = 1'b1; tick();
      check("w_after_col", 32'(w_dout1), 32'hEE34);
      check("w_after_col_flag", 32'(w_collision), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
